// File: rtl/logicnet_input_quantizer.sv
// Input feeder for the layer0 neuron array: quantizes raw features by shift-and-saturate
// and packs NUM_FEATURES codes into one vector handed downstream on valid/ready.
module logicnet_input_quantizer #(
    parameter int unsigned NUM_FEATURES = 8,
    parameter int unsigned IN_WIDTH     = 16,
    parameter int unsigned BITS         = 2,
    parameter int unsigned SHIFT        = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [IN_WIDTH-1:0]          s_data,
    input  logic                         s_last,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NUM_FEATURES*BITS-1:0] m_data,
    output logic                         err_len
);

    localparam int unsigned VEC_W = NUM_FEATURES * BITS;
    localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_FEATURES - 1);
    localparam logic [IN_WIDTH-1:0] CODE_MAX = IN_WIDTH'((1 << BITS) - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_HOLD    = 2'd1,
        ST_DROP    = 2'd2
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [VEC_W-1:0] r_asm;
    logic [VEC_W-1:0] r_m_data;
    logic             r_m_valid;
    logic             r_s_ready;
    logic             r_err_len;

    logic [IN_WIDTH-1:0] w_q;
    logic [BITS-1:0]     w_code;
    logic [VEC_W-1:0]    w_merged;
    logic                w_accept;
    logic                w_free;
    logic                w_at_last;

    // Quantize the incoming beat and form the completed vector including it.
    always_comb begin
        w_q      = s_data >> SHIFT;
        w_code   = (w_q > CODE_MAX) ? CODE_MAX[BITS-1:0] : w_q[BITS-1:0];
        w_merged = r_asm;
        w_merged[(NUM_FEATURES-1)*BITS +: BITS] = w_code;
    end

    assign w_accept  = s_valid & r_s_ready;
    assign w_free    = ~r_m_valid | m_ready;
    assign w_at_last = (r_idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_COLLECT;
            r_idx     <= '0;
            r_asm     <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_s_ready <= 1'b0;
            r_err_len <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            r_s_ready <= 1'b1;
            // Drain by default; a load below on the same edge overrides it.
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
            end
            unique case (r_state)
                ST_COLLECT: begin
                    if (w_accept) begin
                        if (!w_at_last) begin
                            if (s_last) begin
                                r_err_len <= 1'b1;
                                r_asm     <= '0;
                                r_idx     <= '0;
                            end else begin
                                r_asm[r_idx*BITS +: BITS] <= w_code;
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else if (s_last) begin
                            r_idx <= '0;
                            if (w_free) begin
                                r_m_data  <= w_merged;
                                r_m_valid <= 1'b1;
                            end else begin
                                r_asm     <= w_merged;
                                r_state   <= ST_HOLD;
                                r_s_ready <= 1'b0;
                            end
                        end else begin
                            r_err_len <= 1'b1;
                            r_asm     <= '0;
                            r_idx     <= '0;
                            r_state   <= ST_DROP;
                        end
                    end
                end
                ST_HOLD: begin
                    if (w_free) begin
                        r_m_data  <= r_asm;
                        r_m_valid <= 1'b1;
                        r_state   <= ST_COLLECT;
                    end else begin
                        r_s_ready <= 1'b0;
                    end
                end
                ST_DROP: begin
                    if (w_accept && s_last) begin
                        r_idx   <= '0;
                        r_state <= ST_COLLECT;
                    end
                end
                default: begin
                    r_state <= ST_COLLECT;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign s_ready = r_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign err_len = r_err_len;

endmodule
